seg_serial_shifter: RTL and testbench

Parallel-to-serial driver between the 8-digit hex-to-segment encoder and the board's daisy-chained 74HC595 display shift registers. On a start request it captures the 64-bit segment image, shifts it out MSB-first on a divided serial clock, then pulses the register latch. It lets one FPGA pin set drive all eight digits, and it sits directly downstream of the segment encoder's 64-bit output.

---
 rtl/seg_serial_shifter_pkg.sv | 26 ++
 rtl/seg_shift_tick.sv | 29 ++
 rtl/seg_serial_shifter.sv | 95 +++++++++
 tb/tb_seg_serial_shifter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/seg_serial_shifter_pkg.sv
// Shared display definitions for the 74HC595 serial driver: FSM states,
// default frame width and divider range helpers.
package seg_serial_shifter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LATCH,
    ST_DONE
  } seg_state_t;

  localparam int SEG_FRAME_W = 64;
  localparam int SEG_DIV_MIN = 1;

  // Out-of-range dividers collapse to the fastest legal setting.
  function automatic int seg_div_clamp(input int div);
    return (div < SEG_DIV_MIN) ? SEG_DIV_MIN : div;
  endfunction

  // A DIV of 1 still needs a one-bit counter to exist.
  function automatic int seg_div_cnt_w(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/seg_shift_tick.sv
// DIV-cycle down-counter; tick marks the last cycle of each phase and the
// counter reloads itself, so a phase lasts exactly DIV cycles.
module seg_shift_tick #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);
  import seg_serial_shifter_pkg::*;

  localparam int DIV_C = seg_div_clamp(DIV);
  localparam int CW    = seg_div_cnt_w(DIV_C);
  localparam logic [CW-1:0] RELOAD = CW'(DIV_C - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || restart || cnt_reg == '0) begin
      cnt_reg <= RELOAD;
    end else begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign tick = (cnt_reg == '0);

endmodule

// File: rtl/seg_serial_shifter.sv
// Captures a segment image and shifts it MSB-first into a 74HC595 chain,
// then pulses the storage latch. All s_* outputs are registered.
module seg_serial_shifter
  import seg_serial_shifter_pkg::*;
#(
  parameter int WIDTH = SEG_FRAME_W,
  parameter int DIV   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] par_data,
  output logic             s_clk,
  output logic             s_data,
  output logic             s_latch,
  output logic             s_clr_n,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  seg_state_t       state_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [BW-1:0]    bit_cnt_reg;
  logic             tick;
  logic             restart;

  // Phase timer is held at reload outside the timed phases.
  assign restart = (state_reg == ST_IDLE) || (state_reg == ST_DONE);

  seg_shift_tick #(
    .DIV(DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      s_clk       <= 1'b0;
      s_data      <= 1'b0;
      s_latch     <= 1'b0;
      s_clr_n     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      // Pins follow the state one cycle later, which keeps s_data settled
      // a full phase before every s_clk rise.
      s_clr_n <= 1'b1;
      busy    <= (state_reg != ST_IDLE);
      s_clk   <= (state_reg == ST_SHIFT_HI);
      s_latch <= (state_reg == ST_LATCH);
      done    <= (state_reg == ST_DONE);
      s_data  <= ((state_reg == ST_SHIFT_LO) || (state_reg == ST_SHIFT_HI))
                 ? shift_reg[WIDTH-1] : 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            shift_reg   <= par_data;
            bit_cnt_reg <= '0;
            state_reg   <= ST_SHIFT_LO;
          end
        end
        ST_SHIFT_LO: begin
          if (tick) state_reg <= ST_SHIFT_HI;
        end
        ST_SHIFT_HI: begin
          if (tick) begin
            shift_reg   <= {shift_reg[WIDTH-2:0], 1'b0};
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            state_reg   <= (bit_cnt_reg == LAST_BIT) ? ST_LATCH : ST_SHIFT_LO;
          end
        end
        ST_LATCH: begin
          if (tick) state_reg <= ST_DONE;
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_serial_shifter.sv
// Bench for seg_serial_shifter: a model 595 chain and edge-count timing
// expectations for DIV=2 frames, plus a held-start DIV=1 instance.
module tb_seg_serial_shifter;

  localparam int W      = 64;
  localparam int D      = 2;
  localparam int LATCH_E = 1 + 2 * D * W;
  localparam int DONE_E  = 1 + 2 * D * W + D;
  localparam int D1_DONE = 1 + 2 * W + 1;
  localparam int D1_PER  = 2 * W + 3;

  typedef struct {
    logic [63:0] data;
    bit          corrupt;
    int          busy_start;
    int          rst_at;
  } vec_t;

  logic          clk;
  logic          rst, start;
  logic [W-1:0]  par_data;
  logic          s_clk, s_data, s_latch, s_clr_n, busy, done;

  logic          rst1, start1;
  logic [W-1:0]  par_data1;
  logic          s_clk1, s_data1, s_latch1, s_clr_n1, busy1, done1;

  int vectors;
  int miscompares;

  seg_serial_shifter #(.WIDTH(W), .DIV(D)) dut (
    .clk(clk), .rst(rst), .start(start), .par_data(par_data),
    .s_clk(s_clk), .s_data(s_data), .s_latch(s_latch), .s_clr_n(s_clr_n),
    .busy(busy), .done(done)
  );

  seg_serial_shifter #(.WIDTH(W), .DIV(1)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .par_data(par_data1),
    .s_clk(s_clk1), .s_data(s_data1), .s_latch(s_latch1), .s_clr_n(s_clr_n1),
    .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input vec_t v, input int idx);
    int rises, latch_cnt, latch_first, done_cnt, done_first, unstable;
    logic [63:0] cap;
    logic prev_clk, prev_data;
    rises = 0; latch_cnt = 0; latch_first = -1;
    done_cnt = 0; done_first = -1; unstable = 0; cap = '0;
    @(negedge clk);
    par_data = v.data;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (v.corrupt) par_data = '1;
    prev_clk = s_clk;
    prev_data = s_data;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) begin
        chk($sformatf("v%0d busy_edge1", idx), busy, 1);
        chk($sformatf("v%0d s_data_edge1", idx), s_data, v.data[63]);
      end
      if (s_clk && !prev_clk) begin
        rises++;
        cap = {cap[62:0], s_data};
        if (s_data !== prev_data) unstable++;
      end
      if (s_latch) begin
        if (latch_cnt == 0) latch_first = n;
        latch_cnt++;
      end
      if (done) begin
        if (done_cnt == 0) done_first = n;
        done_cnt++;
      end
      if (v.rst_at >= 0 && n == v.rst_at + 1) begin
        chk($sformatf("v%0d outputs_after_rst", idx),
            {s_clk, s_data, s_latch, s_clr_n, busy, done}, 0);
        rst = 1'b0;
      end
      if (v.rst_at < 0 && n == DONE_E + 1)
        chk($sformatf("v%0d busy_fall", idx), busy, 0);
      prev_clk = s_clk;
      prev_data = s_data;
      if (n == v.busy_start - 1) start = 1'b1;
      if (n == v.busy_start) start = 1'b0;
      if (n == v.rst_at) rst = 1'b1;
    end
    if (v.rst_at < 0) begin
      chk($sformatf("v%0d chain_image", idx), cap, v.data);
      chk($sformatf("v%0d clk_rises", idx), rises, W);
      chk($sformatf("v%0d latch_first", idx), latch_first, LATCH_E);
      chk($sformatf("v%0d latch_len", idx), latch_cnt, D);
      chk($sformatf("v%0d done_edge", idx), done_first, DONE_E);
      chk($sformatf("v%0d done_count", idx), done_cnt, 1);
      chk($sformatf("v%0d data_unstable", idx), unstable, 0);
    end else begin
      chk($sformatf("v%0d aborted_latch", idx), latch_cnt, 0);
      chk($sformatf("v%0d aborted_done", idx), done_cnt, 0);
    end
  endtask

  initial begin
    vec_t vecs[8];
    logic [63:0] exp_q[$];
    logic [63:0] cap1;
    logic [63:0] expv;
    logic prev1;
    int rises1, toggles1, dones1, exp_done;

    vectors = 0;
    miscompares = 0;
    vecs[0] = '{64'h8000_0000_0000_0001, 1'b0, -1, -1};
    vecs[1] = '{{$urandom(), $urandom()}, 1'b1, -1, -1};
    vecs[2] = '{{$urandom(), $urandom()}, 1'b0, 100, -1};
    vecs[3] = '{{$urandom(), $urandom()}, 1'b0, -1, 50};
    vecs[4] = '{{$urandom(), $urandom()}, 1'b0, -1, -1};
    vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, -1, -1};
    vecs[6] = '{64'h0, 1'b0, -1, -1};
    vecs[7] = '{{$urandom(), $urandom()}, 1'b0, -1, -1};

    // Reset behaviour.
    rst = 1'b1; start = 1'b0; par_data = '0;
    rst1 = 1'b1; start1 = 1'b0; par_data1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst s_clk", s_clk, 0);
    chk("rst s_data", s_data, 0);
    chk("rst s_latch", s_latch, 0);
    chk("rst s_clr_n", s_clr_n, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("release s_clr_n", s_clr_n, 1);
    chk("release others", {s_clk, s_data, s_latch, busy, done}, 0);
    chk("held rst1 s_clr_n", s_clr_n1, 0);

    for (int i = 0; i < 8; i++) run_frame(vecs[i], i);

    // DIV=1 with start held high: frames repeat with a one-cycle IDLE gap.
    @(negedge clk);
    rst1 = 1'b0;
    start1 = 1'b1;
    par_data1 = {$urandom(), $urandom()};
    exp_q.push_back(par_data1);
    @(posedge clk);
    #1;
    prev1 = s_clk1;
    cap1 = '0; rises1 = 0; toggles1 = 0; dones1 = 0;
    exp_done = D1_DONE;
    for (int n = 1; n <= 3 * D1_PER + 5; n++) begin
      @(posedge clk);
      #1;
      if (s_clk1 !== prev1) toggles1++;
      if (s_clk1 && !prev1) begin
        rises1++;
        cap1 = {cap1[62:0], s_data1};
      end
      prev1 = s_clk1;
      if (done1) begin
        dones1++;
        expv = exp_q.pop_front();
        chk($sformatf("div1 f%0d done_edge", dones1), n, exp_done);
        chk($sformatf("div1 f%0d image", dones1), cap1, expv);
        chk($sformatf("div1 f%0d rises", dones1), rises1, W);
        chk($sformatf("div1 f%0d toggles", dones1), toggles1, 2 * W);
        exp_done += D1_PER;
        cap1 = '0; rises1 = 0; toggles1 = 0;
        par_data1 = {$urandom(), $urandom()};
        exp_q.push_back(par_data1);
      end
    end
    chk("div1 frame_count", dones1, 3);
    start1 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
